// File: rtl/add_stim_checker.sv
// ---------------------------------------------------------------------------
// add_stim_checker
//
// Self-checking initiator for a WIDTH-bit adder (C = A + B, carry discarded).
// Drives a pseudo-random operand stream on A/B from a 16-bit Galois LFSR.
// After LATENCY cycles it samples the returned sum C and compares it with
// (A + B) mod 2^WIDTH. It keeps an error count, the index of the first
// failing vector and a pass flag for the whole run.
//
// Ports:
//   clk           in   rising-edge clock for all state
//   rst           in   asynchronous, active-high reset
//   start         in   single-cycle pulse, begins a run when not busy
//   A, B          out  registered operands to the adder under test
//   C             in   sum returned by the adder under test
//   busy          out  run in progress
//   done          out  run complete, held until the next start
//   pass          out  valid with done: 1 when no mismatches were seen
//   err_count     out  mismatches in this run, saturating at 16'hFFFF
//   first_err_idx out  index of the first mismatching vector, 16'hFFFF if none
//   vec_idx       out  index of the vector currently in flight
// ---------------------------------------------------------------------------
module add_stim_checker #(
  parameter int          WIDTH       = 16,
  parameter int          NUM_VECTORS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [15:0] SEED        = 16'h0001,
  parameter logic [15:0] B_MASK      = 16'h5A5A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx,
  output logic [15:0]      vec_idx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(LATENCY - 1);
  localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] NO_ERR    = 16'hFFFF;

  state_t           r_state;
  state_t           w_nextState;
  logic [15:0]      r_lfsr;
  logic [CW-1:0]    r_waitCnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_errCount;
  logic [15:0]      r_firstErrIdx;
  logic [15:0]      r_vecIdx;

  logic [15:0]      w_lfsrNext;
  logic [WIDTH-1:0] w_expected;
  logic             w_mismatch;
  logic             w_lastVec;
  logic [15:0]      w_errNext;

  // Datapath helpers: next LFSR state, expected sum and the CHECK result.
  // The compare is written so that an unknown C falls through to the
  // mismatch branch.
  always_comb begin
    w_lfsrNext = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
    w_expected = r_a + r_b;
    w_lastVec  = (r_vecIdx == LAST_IDX);
    if (C == w_expected) begin
      w_mismatch = 1'b0;
    end else begin
      w_mismatch = 1'b1;
    end
    w_errNext = r_errCount;
    if (w_mismatch && (r_errCount != 16'hFFFF)) begin
      w_errNext = r_errCount + 16'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A start pulse only matters in IDLE or DONE, so a
  // start during a run is simply ignored.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_nextState = ST_DRIVE;
      ST_DRIVE: w_nextState = ST_WAIT;
      ST_WAIT:  if (r_waitCnt == '0) w_nextState = ST_CHECK;
      ST_CHECK: w_nextState = w_lastVec ? ST_DONE : ST_DRIVE;
      ST_DONE:  if (start) w_nextState = ST_DRIVE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Datapath registers. Operands are loaded only on the transition into
  // DRIVE (from the seed on a new run, from the advanced LFSR otherwise),
  // so they stay stable through WAIT and CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr        <= SEED_EFF;
      r_waitCnt     <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_errCount    <= 16'h0000;
      r_firstErrIdx <= NO_ERR;
      r_vecIdx      <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_lfsr        <= SEED_EFF;
            r_a           <= WIDTH'(SEED_EFF);
            r_b           <= WIDTH'(SEED_EFF ^ B_MASK);
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_errCount    <= 16'h0000;
            r_firstErrIdx <= NO_ERR;
            r_vecIdx      <= 16'h0000;
          end
        end
        ST_DRIVE: begin
          r_waitCnt <= WAIT_LOAD;
        end
        ST_WAIT: begin
          if (r_waitCnt != '0) begin
            r_waitCnt <= r_waitCnt - CW'(1);
          end
        end
        ST_CHECK: begin
          r_errCount <= w_errNext;
          if (w_mismatch && (r_errCount == 16'h0000)) begin
            r_firstErrIdx <= r_vecIdx;
          end
          r_lfsr <= w_lfsrNext;
          if (w_lastVec) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (w_errNext == 16'h0000);
          end else begin
            r_vecIdx <= r_vecIdx + 16'd1;
            r_a      <= WIDTH'(w_lfsrNext);
            r_b      <= WIDTH'(w_lfsrNext ^ B_MASK);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign A             = r_a;
  assign B             = r_b;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_errCount;
  assign first_err_idx = r_firstErrIdx;
  assign vec_idx       = r_vecIdx;

endmodule

// File: tb/tb_add_stim_checker.sv
// ---------------------------------------------------------------------------
// tb_add_stim_checker
//
// Plays the adder under test for two checker instances: the default
// configuration (SEED 1, 256 vectors, latency 2) and a small wrap-around
// configuration (SEED 16'hFFFF, 3 vectors, latency 1). The adder can be
// correct, have one sum bit stuck at 0, or corrupt random vectors.
// Expected operand vectors are queued when a run is started and a negedge
// monitor pops and compares them as the checker presents each new vector.
// ---------------------------------------------------------------------------
module tb_add_stim_checker;

  localparam int N      = 256;
  localparam int LAT    = 2;
  localparam int PERIOD = LAT + 2;

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A, B, C;
  logic        busy, done, pass;
  logic [15:0] err_count, first_err_idx, vec_idx;

  logic        start2 = 1'b0;
  logic [15:0] A2, B2, C2;
  logic        busy2, done2, pass2;
  logic [15:0] errCount2, firstErrIdx2, vecIdx2;

  int          mode     = 0;
  int          stuckBit = 0;
  logic        wrong2   = 1'b0;
  logic [15:0] xorArr[N];
  logic [15:0] modelA[N];
  logic [15:0] sum1;

  int          testsRun    = 0;
  int          testsFailed = 0;

  vec_t        expQ[$];
  vec_t        monVec;
  logic        prevBusy = 1'b0;
  int          holdCnt  = 0;
  logic [15:0] lastA    = '0;
  logic [15:0] lastB    = '0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  add_stim_checker dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B), .C(C),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx), .vec_idx(vec_idx)
  );

  add_stim_checker #(.NUM_VECTORS(3), .LATENCY(1), .SEED(16'hFFFF)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .A(A2), .B(B2), .C(C2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(errCount2), .first_err_idx(firstErrIdx2), .vec_idx(vecIdx2)
  );

  // Behavioural adder for the main instance, with selectable faults.
  always_comb begin
    sum1 = A + B;
    C    = sum1;
    if (mode == 1) begin
      C = sum1 & ~(16'h0001 << stuckBit);
    end else if (mode == 2) begin
      C = sum1 ^ xorArr[vec_idx[7:0]];
    end
  end

  // Behavioural adder for the wrap-around instance; optionally returns
  // the sum off by one on vector 0.
  always_comb begin
    C2 = A2 + B2 + ((wrong2 && (vecIdx2 == 16'd0)) ? 16'd1 : 16'd0);
  end

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference operand sequence: A walks the Galois LFSR from seed 1.
  task automatic buildModel();
    logic [15:0] s;
    s = 16'h0001;
    for (int i = 0; i < N; i++) begin
      modelA[i] = s;
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
  endtask

  // Monitor: every time the checker presents a new operand pair while busy,
  // pop the next expected vector and compare. It also checks that each
  // pair was held for a full vector period.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      prevBusy = 1'b0;
      holdCnt  = 0;
    end else begin
      if (busy && (!prevBusy || (A !== lastA) || (B !== lastB))) begin
        if (prevBusy) checkOutput("hold_cycles", holdCnt, PERIOD);
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL queue_underflow: got unexpected vector A=%h B=%h", A, B);
        end else begin
          monVec = expQ.pop_front();
          checkOutput("mon_A", A, monVec.a);
          checkOutput("mon_B", B, monVec.b);
          checkOutput("mon_vec_idx", vec_idx, monVec.idx);
        end
        holdCnt = 1;
      end else if (busy) begin
        holdCnt++;
      end else if (prevBusy) begin
        checkOutput("hold_cycles_last", holdCnt, PERIOD);
      end
      prevBusy = busy;
      lastA    = A;
      lastB    = B;
    end
  end

  // Reset values of the main instance.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_A"}, A, 16'h0000);
    checkOutput({tag, "_B"}, B, 16'h0000);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_pass"}, pass, 1'b0);
    checkOutput({tag, "_err_count"}, err_count, 16'h0000);
    checkOutput({tag, "_first_err_idx"}, first_err_idx, 16'hFFFF);
    checkOutput({tag, "_vec_idx"}, vec_idx, 16'h0000);
  endtask

  // Queue the expected vectors for a run and pulse start.
  task automatic beginRun();
    for (int i = 0; i < N; i++) begin
      expQ.push_back('{i, modelA[i], modelA[i] ^ 16'h5A5A});
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // One full run of the main instance in adder mode m. restartAt >= 0
  // fires an extra start while that vector is in flight. Final results are
  // compared with error counts derived from the reference sequence.
  task automatic applyStimulus(input int m, input int restartAt, input bit checkConst);
    int          errs;
    int          first;
    int          cycles;
    bit          injected;
    bit          bad;
    logic [15:0] a, b, s;
    mode  = m;
    errs  = 0;
    first = 16'hFFFF;
    for (int i = 0; i < N; i++) begin
      a   = modelA[i];
      b   = a ^ 16'h5A5A;
      s   = a + b;
      bad = 1'b0;
      if (m == 1) bad = s[stuckBit];
      else if (m == 2) bad = (xorArr[i] != 16'h0000);
      if (bad) begin
        if (errs == 0) first = i;
        errs++;
      end
    end
    beginRun();
    if (checkConst) begin
      checkOutput("vec0_A", A, 16'h0001);
      checkOutput("vec0_B", B, 16'h5A5B);
    end
    cycles   = 0;
    injected = 1'b0;
    while (!done && cycles < N * PERIOD + 50) begin
      @(posedge clk);
      cycles++;
      #1 start = 1'b0;
      if (checkConst && cycles == PERIOD) begin
        checkOutput("vec1_A", A, 16'hB400);
        checkOutput("vec1_B", B, 16'hEE5A);
      end
      if (!done && !injected && restartAt >= 0 && vec_idx == 16'(restartAt)) begin
        start    = 1'b1;
        injected = 1'b1;
      end
    end
    start = 1'b0;
    checkOutput("run_cycles", cycles, N * PERIOD);
    @(negedge clk);
    #1;
    checkOutput("err_count", err_count, errs);
    checkOutput("first_err_idx", first_err_idx, first);
    checkOutput("pass", pass, (errs == 0));
    checkOutput("busy_end", busy, 1'b0);
    checkOutput("done_end", done, 1'b1);
    checkOutput("queue_empty", expQ.size(), 0);
  endtask

  // Asynchronous reset during the WAIT phase of vector 37, then a clean run.
  task automatic resetMidRun();
    int n;
    mode = 0;
    beginRun();
    n = 0;
    while (vec_idx != 16'd37 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_vec37", vec_idx, 16'd37);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkResetValues("async_rst");
    @(negedge clk);
    #1 rst = 1'b0;
    applyStimulus(0, -1, 1'b1);
  endtask

  // Run of the wrap-around instance: seed 16'hFFFF, so the first sum
  // overflows and must wrap to 16'hA5A4.
  task automatic runWrap(input logic w);
    int cycles;
    wrong2 = w;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    checkOutput("wrap_A", A2, 16'hFFFF);
    checkOutput("wrap_B", B2, 16'hA5A5);
    cycles = 0;
    while (!done2 && cycles < 100) begin
      @(posedge clk);
      cycles++;
      #1;
    end
    checkOutput("wrap_cycles", cycles, 9);
    checkOutput("wrap_err_count", errCount2, w ? 16'd1 : 16'd0);
    checkOutput("wrap_first_err_idx", firstErrIdx2, w ? 16'd0 : 16'hFFFF);
    checkOutput("wrap_pass", pass2, !w);
  endtask

  // Main sequence.
  initial begin
    for (int i = 0; i < N; i++) xorArr[i] = 16'h0000;
    buildModel();
    #1 rst = 1'b1;
    #3 checkResetValues("reset");
    @(negedge clk);
    #1 rst = 1'b0;

    applyStimulus(0, -1, 1'b1);

    stuckBit = 0;
    applyStimulus(1, -1, 1'b0);
    stuckBit = $urandom_range(15, 1);
    applyStimulus(1, -1, 1'b0);

    for (int i = 0; i < N; i++) begin
      xorArr[i] = ($urandom_range(7, 0) == 0) ? 16'($urandom_range(65535, 1)) : 16'h0000;
    end
    applyStimulus(2, 10, 1'b0);
    applyStimulus(2, -1, 1'b0);

    resetMidRun();

    runWrap(1'b0);
    runWrap(1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
